// File: rtl/audio_sample_sequencer.sv
// Sample-rate scheduler: programmable frame clock, sample strobe and filter handshake.
// Optional overrun counter output enabled by defining SEQ_OVERRUN_CNT_EN.
module audio_sample_sequencer #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             sample_stb,
  output logic             filt_req,
  input  logic             filt_ack,
  input  logic             filt_done,
  output logic             busy,
  output logic [15:0]      sample_idx,
  output logic             overrun
`ifdef SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]       overrun_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_BUSY
  } state_e;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] nxt_q, nxt_d;
  logic             clk_out_q, clk_out_d;
  logic             stb_q, stb_d;
  logic             cfg_err_q, cfg_err_d;
  state_e           state_q, state_d;
  logic [15:0]      idx_q, idx_d;
  logic             overrun_q, overrun_d;
  state_e           resume_state;
`ifdef SEQ_OVERRUN_CNT_EN
  logic [7:0]       ocnt_q, ocnt_d;
`endif

  // Period counter, frame clock and configuration shadow register.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    nxt_d     = nxt_q;
    clk_out_d = 1'b0;
    stb_d     = 1'b0;
    cfg_err_d = 1'b0;
    if (enable) begin
      clk_out_d = (cnt_q >= (per_q >> 1));
      if (cnt_q == per_q - ONE) begin
        cnt_d = '0;
        per_d = nxt_q;
        stb_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = '0;
    end
    // While running, a new period only lands at the wrap so no period is ever cut short.
    if (cfg_load) begin
      if (cfg_div < MIN_DIV) begin
        cfg_err_d = 1'b1;
      end else begin
        nxt_d = cfg_div;
        if (!enable) per_d = cfg_div;
      end
    end
  end

  // Handshake FSM; a strobe that arrives with the filter still occupied is dropped.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    overrun_d    = 1'b0;
    resume_state = enable ? S_WAIT : S_IDLE;
    case (state_q)
      S_IDLE: if (enable) state_d = S_WAIT;
      S_WAIT: begin
        if (stb_q) begin
          state_d = S_REQ;
          idx_d   = idx_q + 16'd1;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (filt_ack && filt_done) begin
          if (stb_q) begin
            state_d = S_REQ;
            idx_d   = idx_q + 16'd1;
          end else begin
            state_d = resume_state;
          end
        end else begin
          if (filt_ack) state_d = S_BUSY;
          overrun_d = stb_q;
        end
      end
      S_BUSY: begin
        // Completion and a fresh strobe together: the new sample wins, no overrun.
        if (filt_done) begin
          if (stb_q) begin
            state_d = S_REQ;
            idx_d   = idx_q + 16'd1;
          end else begin
            state_d = resume_state;
          end
        end else begin
          overrun_d = stb_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SEQ_OVERRUN_CNT_EN
  always_comb begin
    ocnt_d = ocnt_q;
    if (overrun_d && (ocnt_q != 8'hFF)) ocnt_d = ocnt_q + 8'd1;
  end
`endif

  // NOTE: state updates use non-blocking assignments; reset here is synchronous active-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      per_q     <= DEF_DIV;
      nxt_q     <= DEF_DIV;
      clk_out_q <= 1'b0;
      stb_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      state_q   <= S_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
`ifdef SEQ_OVERRUN_CNT_EN
      ocnt_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      nxt_q     <= nxt_d;
      clk_out_q <= clk_out_d;
      stb_q     <= stb_d;
      cfg_err_q <= cfg_err_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
`ifdef SEQ_OVERRUN_CNT_EN
      ocnt_q    <= ocnt_d;
`endif
    end
  end

  assign cfg_err    = cfg_err_q;
  assign clk_out    = clk_out_q;
  assign sample_stb = stb_q;
  assign filt_req   = (state_q == S_REQ);
  assign busy       = (state_q == S_REQ) || (state_q == S_BUSY);
  assign sample_idx = idx_q;
  assign overrun    = overrun_q;
`ifdef SEQ_OVERRUN_CNT_EN
  assign overrun_cnt = ocnt_q;
`endif

endmodule
